// File: rtl/multicore_launcher.sv
`default_nettype none
// ============================================================================
// Module      : multicore_launcher
// Description : Waits for all selected cores to be ready, pulses a one-cycle
//               active-low start, then tracks completion and run length.
// Revision    : 1.0 - initial release
// ============================================================================
module multicore_launcher #(
    parameter int CORE_COUNT = 4,
    parameter int CYC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CORE_COUNT-1:0] core_mask,
    input  logic [CORE_COUNT-1:0] core_ready,
    input  logic [CORE_COUNT-1:0] core_done,
    output logic [CORE_COUNT-1:0] core_startN,
    output logic                  busy,
    output logic                  all_done,
    output logic [CORE_COUNT-1:0] done_flags,
    output logic [CYC_WIDTH-1:0]  cycle_count
);

    localparam logic [CYC_WIDTH-1:0] c_CYC_ONE = {{(CYC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_READY = 3'd1,
        S_LAUNCH     = 3'd2,
        S_RUN        = 3'd3,
        S_FINISH     = 3'd4
    } state_t;

    state_t                r_state;
    logic [CORE_COUNT-1:0] r_maskQ;
    logic [CORE_COUNT-1:0] r_doneP;
    logic [CORE_COUNT-1:0] r_doneFlags;
    logic [CORE_COUNT-1:0] r_startN;
    logic [CYC_WIDTH-1:0]  r_cycleCount;
    logic                  r_busy;
    logic                  r_allDone;

    logic                  w_accept;
    logic                  w_allReady;
    logic [CORE_COUNT-1:0] w_doneRise;
    logic [CORE_COUNT-1:0] w_flagsNext;
    logic                  w_cntMax;

    assign w_accept    = start && (core_mask != '0);
    assign w_allReady  = (core_ready & r_maskQ) == r_maskQ;
    // Only a fresh 0->1 transition counts, so a level left over from the last run is ignored.
    assign w_doneRise  = core_done & ~r_doneP & r_maskQ;
    assign w_flagsNext = r_doneFlags | w_doneRise;
    assign w_cntMax    = &r_cycleCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_maskQ      <= '0;
            r_doneP      <= '0;
            r_doneFlags  <= '0;
            r_startN     <= '1;
            r_cycleCount <= '0;
            r_busy       <= 1'b0;
            r_allDone    <= 1'b0;
        end else begin
            r_doneP  <= core_done;
            r_startN <= '1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_maskQ <= core_mask;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT_READY;
                    end
                end
                S_WAIT_READY: begin
                    // Start pulse and run-state clearing are registered on entry to LAUNCH.
                    if (w_allReady) begin
                        r_startN     <= ~r_maskQ;
                        r_doneFlags  <= '0;
                        r_cycleCount <= '0;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_doneFlags <= w_flagsNext;
                    if (!w_cntMax) begin
                        r_cycleCount <= r_cycleCount + c_CYC_ONE;
                    end
                    if ((w_flagsNext & r_maskQ) == r_maskQ) begin
                        r_busy    <= 1'b0;
                        r_allDone <= 1'b1;
                        r_state   <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    if (w_accept) begin
                        r_maskQ   <= core_mask;
                        r_busy    <= 1'b1;
                        r_allDone <= 1'b0;
                        r_state   <= S_WAIT_READY;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_startN = r_startN;
    assign busy        = r_busy;
    assign all_done    = r_allDone;
    assign done_flags  = r_doneFlags;
    assign cycle_count = r_cycleCount;

endmodule
`default_nettype wire

// File: tb/tb_multicore_launcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicore_launcher
// Description : Directed self-checking bench for multicore_launcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicore_launcher;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  core_mask;
    logic [3:0]  core_ready;
    logic [3:0]  core_done;
    logic [3:0]  core_startN;
    logic        busy;
    logic        all_done;
    logic [3:0]  done_flags;
    logic [23:0] cycle_count;
    logic [3:0]  startN4;
    logic        busy4;
    logic        allDone4;
    logic [3:0]  flags4;
    logic [3:0]  count4;

    int passed = 0;
    int total  = 0;

    multicore_launcher #(.CORE_COUNT(4), .CYC_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .start(start), .core_mask(core_mask),
        .core_ready(core_ready), .core_done(core_done), .core_startN(core_startN),
        .busy(busy), .all_done(all_done), .done_flags(done_flags), .cycle_count(cycle_count)
    );

    // Narrow counter copy to exercise saturation
    multicore_launcher #(.CORE_COUNT(4), .CYC_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .core_mask(core_mask),
        .core_ready(core_ready), .core_done(core_done), .core_startN(startN4),
        .busy(busy4), .all_done(allDone4), .done_flags(flags4), .cycle_count(count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; core_mask = '0; core_ready = '0; core_done = '0;
        step; step;
        total++; if (core_startN !== 4'hF) $display("FAIL rst_startN got=%h exp=f", core_startN); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
        total++; if (all_done !== 1'b0) $display("FAIL rst_all_done got=%b exp=0", all_done); else passed++;
        total++; if (done_flags !== 4'h0) $display("FAIL rst_flags got=%h exp=0", done_flags); else passed++;
        total++; if (cycle_count !== 24'd0) $display("FAIL rst_count got=%0d exp=0", cycle_count); else passed++;
        rst = 1'b0;
        step;
    endtask

    task automatic test_zero_mask_idle;
        core_ready = 4'hF; core_mask = 4'h0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            total++; if ({busy, core_startN} !== 5'b0_1111) $display("FAIL zmask_idle got busy=%b startN=%h exp busy=0 startN=f", busy, core_startN); else passed++;
        end
        start = 1'b0;
    endtask

    task automatic test_launch_all;
        core_mask = 4'hF; core_ready = 4'hF; core_done = 4'h0; start = 1'b1;
        step;
        start = 1'b0;
        total++; if ({busy, core_startN} !== 5'b1_1111) $display("FAIL t1_accept got busy=%b startN=%h exp busy=1 startN=f", busy, core_startN); else passed++;
        step;
        total++; if (core_startN !== 4'h0) $display("FAIL t1_launch got=%h exp=0", core_startN); else passed++;
        step;
        total++; if (core_startN !== 4'hF) $display("FAIL t1_pulse_end got=%h exp=f", core_startN); else passed++;
        for (int k = 1; k <= 20; k++) begin
            if (k == 5)  core_done[0] = 1'b1;
            if (k == 9)  core_done[1] = 1'b1;
            if (k == 12) core_done[2] = 1'b1;
            if (k == 20) begin
                core_done[3] = 1'b1;
                total++; if ({all_done, done_flags} !== 5'b0_0111) $display("FAIL t1_pre_last got all_done=%b flags=%h exp all_done=0 flags=7", all_done, done_flags); else passed++;
                total++; if (cycle_count !== 24'd19) $display("FAIL t1_pre_count got=%0d exp=19", cycle_count); else passed++;
            end
            step;
        end
        total++; if ({all_done, busy} !== 2'b10) $display("FAIL t1_finish got all_done=%b busy=%b exp 1/0", all_done, busy); else passed++;
        total++; if (cycle_count !== 24'd20) $display("FAIL t1_count got=%0d exp=20", cycle_count); else passed++;
        total++; if (done_flags !== 4'hF) $display("FAIL t1_flags got=%h exp=f", done_flags); else passed++;
        step;
        total++; if ({all_done, cycle_count} !== {1'b1, 24'd20}) $display("FAIL t1_hold got all_done=%b count=%0d exp 1/20", all_done, cycle_count); else passed++;
    endtask

    task automatic test_stale_done;
        core_mask = 4'h1; start = 1'b1;
        step;
        start = 1'b0;
        total++; if ({all_done, busy} !== 2'b01) $display("FAIL t3_restart got all_done=%b busy=%b exp 0/1", all_done, busy); else passed++;
        step;
        total++; if ({done_flags, cycle_count} !== 28'd0) $display("FAIL t3_launch_clear got flags=%h count=%0d exp 0/0", done_flags, cycle_count); else passed++;
        step;
        step; step; step;
        total++; if ({all_done, done_flags} !== 5'b0_0000) $display("FAIL t3_stale got all_done=%b flags=%h exp 0/0", all_done, done_flags); else passed++;
        core_done[0] = 1'b0;
        step;
        core_done[0] = 1'b1;
        step;
        total++; if ({all_done, done_flags} !== 5'b1_0001) $display("FAIL t3_finish got all_done=%b flags=%h exp 1/1", all_done, done_flags); else passed++;
        total++; if (cycle_count !== 24'd5) $display("FAIL t3_count got=%0d exp=5", cycle_count); else passed++;
    endtask

    task automatic test_wait_ready;
        core_done = 4'h0; core_mask = 4'h5; core_ready = 4'h1; start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step;
            total++; if ({busy, core_startN} !== 5'b1_1111) $display("FAIL t2_wait got busy=%b startN=%h exp busy=1 startN=f", busy, core_startN); else passed++;
        end
        core_ready = 4'h5;
        step;
        total++; if (core_startN !== 4'hA) $display("FAIL t2_launch got=%h exp=a", core_startN); else passed++;
        step;
        total++; if (core_startN !== 4'hF) $display("FAIL t2_pulse_end got=%h exp=f", core_startN); else passed++;
        core_done = 4'h5;
        step;
        total++; if ({all_done, done_flags, cycle_count} !== {1'b1, 4'h5, 24'd1}) $display("FAIL t2_finish got all_done=%b flags=%h count=%0d exp 1/5/1", all_done, done_flags, cycle_count); else passed++;
    endtask

    task automatic test_ignore_start;
        core_done = 4'h0; core_ready = 4'hF; core_mask = 4'h0; start = 1'b1;
        step;
        total++; if ({all_done, busy} !== 2'b10) $display("FAIL t4_zmask_finish got all_done=%b busy=%b exp 1/0", all_done, busy); else passed++;
        core_mask = 4'h3;
        step;
        core_mask = 4'hC;
        step;
        total++; if (core_startN !== 4'hC) $display("FAIL t4_launch got=%h exp=c", core_startN); else passed++;
        step;
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) core_done = 4'hC;
            step;
        end
        total++; if ({busy, all_done, cycle_count} !== {2'b10, 24'd6}) $display("FAIL t4_run got busy=%b all_done=%b count=%0d exp 1/0/6", busy, all_done, cycle_count); else passed++;
        start = 1'b0;
        core_done = 4'hF;
        step;
        total++; if ({all_done, done_flags, cycle_count} !== {1'b1, 4'h3, 24'd7}) $display("FAIL t4_finish got all_done=%b flags=%h count=%0d exp 1/3/7", all_done, done_flags, cycle_count); else passed++;
    endtask

    task automatic test_saturation;
        core_done = 4'h0; core_mask = 4'h2; start = 1'b1;
        step;
        start = 1'b0;
        step; step;
        for (int k = 1; k <= 20; k++) begin
            if (k == 17) begin
                total++; if ({count4, cycle_count} !== {4'd15, 24'd16}) $display("FAIL t5_sat got count4=%0d count=%0d exp 15/16", count4, cycle_count); else passed++;
            end
            if (k == 20) core_done[1] = 1'b1;
            step;
        end
        total++; if ({allDone4, count4} !== {1'b1, 4'd15}) $display("FAIL t5_finish4 got all_done=%b count=%0d exp 1/15", allDone4, count4); else passed++;
        total++; if ({all_done, cycle_count} !== {1'b1, 24'd20}) $display("FAIL t5_finish24 got all_done=%b count=%0d exp 1/20", all_done, cycle_count); else passed++;
    endtask

    task automatic test_reset_mid_run;
        core_done = 4'h0; core_mask = 4'hF; start = 1'b1;
        step;
        start = 1'b0;
        step; step;
        core_done[0] = 1'b1;
        step; step;
        total++; if (done_flags !== 4'h1) $display("FAIL t6_pre_flags got=%h exp=1", done_flags); else passed++;
        #3 rst = 1'b1;
        #1;
        total++; if ({core_startN, busy, all_done} !== 6'b1111_00) $display("FAIL t6_async got startN=%h busy=%b all_done=%b exp f/0/0", core_startN, busy, all_done); else passed++;
        total++; if ({done_flags, cycle_count} !== 28'd0) $display("FAIL t6_clear got flags=%h count=%0d exp 0/0", done_flags, cycle_count); else passed++;
        #2 rst = 1'b0;
        core_done = 4'h0;
        for (int i = 0; i < 5; i++) begin
            step;
            total++; if ({busy, core_startN} !== 5'b0_1111) $display("FAIL t6_idle got busy=%b startN=%h exp 0/f", busy, core_startN); else passed++;
        end
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        total++; if (core_startN !== 4'h0) $display("FAIL t6_relaunch got=%h exp=0", core_startN); else passed++;
        step;
        total++; if (core_startN !== 4'hF) $display("FAIL t6_pulse_end got=%h exp=f", core_startN); else passed++;
    endtask

    initial begin
        test_reset();
        test_zero_mask_idle();
        test_launch_all();
        test_stale_done();
        test_wait_ready();
        test_ignore_start();
        test_saturation();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
